mul4_shift_add: RTL

- Sequential 4x4 unsigned shift-add multiplier in the alu4 datapath.
- Sits directly downstream of the 4-bit 2-to-1 operand mux. Each cycle the mux selects either 0 (d0) or the multiplicand (d1), using the current multiplier LSB as select.
- This block adds the selected addend into its partial-product register, shifts, and counts.
- Start/done handshake; presents an 8-bit product to the ALU result path.

---
 rtl/mul4_shift_add.sv | 106 ++++++++++
 1 files changed

// File: rtl/mul4_shift_add.sv
`default_nettype none
// ============================================================================
// Module   : mul4_shift_add
// Brief    : Sequential unsigned shift-add multiplier with start/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module mul4_shift_add #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0]    c_IDLE = 2'd0;
  localparam logic [1:0]    c_RUN  = 2'd1;
  localparam logic [1:0]    c_DONE = 2'd2;
  localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_q;
  logic             r_c;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_addend;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_a_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_accept;
  logic             w_last;

  // Operand mux feeding the adder: multiplicand or zero, selected by Q[0].
  assign w_addend = r_q[0] ? r_m : '0;
  assign w_sum    = {r_c, r_a} + {1'b0, w_addend};
  // Shift {C,A,Q} right by one with 0 entering C.
  assign w_a_next = w_sum[WIDTH:1];
  assign w_q_next = {w_sum[0], r_q[WIDTH-1:1]};

  assign w_accept = (r_state == c_IDLE) && start;
  assign w_last   = (r_state == c_RUN) && (r_cnt == c_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:  if (start) w_state_next = c_RUN;
      c_RUN:   if (r_cnt == c_LAST) w_state_next = c_DONE;
      c_DONE:  w_state_next = c_IDLE;
      default: w_state_next = c_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      c_RUN:   busy = 1'b1;
      c_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_m     <= '0;
      r_a     <= '0;
      r_q     <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      product <= '0;
    end else if (w_accept) begin
      r_m   <= a;
      r_q   <= b;
      r_a   <= '0;
      r_c   <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == c_RUN) begin
      r_a   <= w_a_next;
      r_q   <= w_q_next;
      r_c   <= 1'b0;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        product <= {w_a_next, w_q_next};
      end
    end
  end

endmodule
`default_nettype wire
